// File: rtl/alu_defs_pkg.sv
// ALU control encodings shared by the ALU-control decoder and the execution unit.
// The 4-bit codes are the contract between the two blocks.
package alu_defs_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADDU = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_LUI  = 4'b1001;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b1010;
  localparam logic [ALU_CTRL_W-1:0] ALU_MUL  = 4'b1100;

  // Codes that need more than one cycle in the execution unit.
  function automatic logic is_multicycle(input logic [ALU_CTRL_W-1:0] code);
    return code == ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// done/product are presented combinationally during the last iteration so the caller can register them.
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = mplier[0] ? acc + mcand : acc;
  assign done     = busy && (cnt == LAST);
  assign product  = acc_next;

  // No early exit on a zero multiplier: latency is fixed regardless of operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (cnt == LAST) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU execution unit: valid/ready request in, registered result with zero/overflow out.
// Single-cycle ops are computed at the accept edge; MUL is delegated to alu_mul_iter.
module alu_seq
  import alu_defs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_aluControl,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_next;
  logic             zero_q;
  logic             zero_next;
  logic             ovf_q;
  logic             ovf_next;

  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;
  logic [WIDTH-1:0] op_result;
  logic             op_ovf;

  assign sum  = i_a + i_b;
  assign diff = i_a - i_b;
  assign slt  = $signed(i_a) < $signed(i_b);

  // Single-cycle op mux; MUL and unassigned codes fall through to zero.
  always_comb begin
    op_result = '0;
    op_ovf    = 1'b0;
    case (i_aluControl)
      ALU_ADD: begin
        op_result = sum;
        op_ovf    = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_ADDU: op_result = sum;
      ALU_SUB: begin
        op_result = diff;
        op_ovf    = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_AND: op_result = i_a & i_b;
      ALU_OR:  op_result = i_a | i_b;
      ALU_NOR: op_result = ~(i_a | i_b);
      ALU_LUI: op_result = {i_b[15:0], {(WIDTH-16){1'b0}}};
      ALU_SLT: op_result = {{(WIDTH-1){1'b0}}, slt};
      default: op_result = '0;
    endcase
  end

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .start   (mul_start),
    .a       (i_a),
    .b       (i_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Result registers only change on an accept or MUL completion, so they hold under backpressure.
  always_comb begin
    state_next  = state;
    result_next = result_q;
    zero_next   = zero_q;
    ovf_next    = ovf_q;
    mul_start   = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          if (is_multicycle(i_aluControl)) begin
            mul_start  = 1'b1;
            state_next = MUL;
          end else begin
            result_next = op_result;
            zero_next   = (op_result == '0);
            ovf_next    = op_ovf;
            state_next  = DONE;
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          result_next = mul_product;
          zero_next   = (mul_product == '0);
          ovf_next    = 1'b0;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_next;
      result_q <= result_next;
      zero_q   <= zero_next;
      ovf_q    <= ovf_next;
    end
  end

  assign o_ready    = (state == IDLE);
  assign o_valid    = (state == DONE);
  assign o_result   = result_q;
  assign o_zero     = zero_q;
  assign o_overflow = ovf_q;

endmodule
